// File: rtl/udp_echo_app_ctrl.sv
// udp_echo_app_ctrl: control FSM for the UDP echo application tile.
// Receives a header flit, one metadata flit and N data flits from NoC0.
// It strobes the datapath to capture the header and metadata, then emits the
// rewritten header and metadata. Data flits are streamed straight through.
// Optional feature macro: UDP_ECHO_APP_STATS_EN adds echoed packet/byte counters.

package udp_echo_app_pkg;
  localparam int MSG_LENGTH_WIDTH = 8;
  localparam int UDP_LENGTH_W     = 16;

  typedef enum logic [1:0] {
    HDR_FLIT  = 2'd0,
    META_FLIT = 2'd1,
    DATA_FLIT = 2'd2
  } udp_app_out_mux_sel_e;
endpackage

module udp_echo_app_ctrl
  import udp_echo_app_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        noc0_ctovr_udp_app_in_val,
  output logic                        udp_app_in_noc0_ctovr_rdy,
  output logic                        udp_app_out_noc0_vrtoc_val,
  input  logic                        noc0_vrtoc_udp_app_out_rdy,
  output logic                        in_store_hdr_flit,
  output logic                        in_store_meta_flit,
  output udp_app_out_mux_sel_e        out_data_mux_sel,
  input  logic [MSG_LENGTH_WIDTH-1:0] total_flits,
  input  logic [UDP_LENGTH_W-1:0]     data_length
`ifdef UDP_ECHO_APP_STATS_EN
  ,
  output logic [31:0]                 echo_pkt_count,
  output logic [31:0]                 echo_byte_count
`endif
);

  typedef enum logic [2:0] {
    RX_HDR    = 3'd0,
    RX_META   = 3'd1,
    TX_HDR    = 3'd2,
    TX_META   = 3'd3,
    PASS_DATA = 3'd4
  } state_e;

  state_e                      state;
  state_e                      state_next;
  logic [MSG_LENGTH_WIDTH-1:0] data_cnt;
  logic [MSG_LENGTH_WIDTH-1:0] data_cnt_load;
  logic                        cnt_load;
  logic                        data_beat;
  logic                        last_beat;
  logic                        pkt_done;

  // Data flits following the metadata; a malformed length of 0 yields no data.
  function automatic logic [MSG_LENGTH_WIDTH-1:0] sat_dec(
    input logic [MSG_LENGTH_WIDTH-1:0] n
  );
    if (n == '0) return '0;
    return n - MSG_LENGTH_WIDTH'(1);
  endfunction

  assign data_cnt_load = sat_dec(total_flits);
  assign cnt_load      = (state == TX_META) && noc0_vrtoc_udp_app_out_rdy;
  assign data_beat     = (state == PASS_DATA) && noc0_ctovr_udp_app_in_val
                         && noc0_vrtoc_udp_app_out_rdy;
  // A count of 0 here cannot occur in normal flow; treat it as the last beat
  // so the FSM can never get stuck or underflow.
  assign last_beat     = data_beat && (data_cnt <= MSG_LENGTH_WIDTH'(1));
  assign pkt_done      = (cnt_load && (data_cnt_load == '0)) || last_beat;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= RX_HDR;
    else     state <= state_next;
  end

  // Remaining data-flit down-counter
  always_ff @(posedge clk) begin
    if (rst) begin
      data_cnt <= '0;
    end else if (cnt_load) begin
      data_cnt <= data_cnt_load;
    end else if (data_beat && (data_cnt != '0)) begin
      data_cnt <= data_cnt - MSG_LENGTH_WIDTH'(1);
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      RX_HDR:    if (noc0_ctovr_udp_app_in_val) state_next = RX_META;
      RX_META:   if (noc0_ctovr_udp_app_in_val) state_next = TX_HDR;
      TX_HDR:    if (noc0_vrtoc_udp_app_out_rdy) state_next = TX_META;
      TX_META: begin
        if (noc0_vrtoc_udp_app_out_rdy) begin
          state_next = (data_cnt_load == '0) ? RX_HDR : PASS_DATA;
        end
      end
      PASS_DATA: if (last_beat) state_next = RX_HDR;
      default:   state_next = RX_HDR;
    endcase
  end

  // Handshake, strobe and mux outputs; all forced idle while in reset
  always_comb begin
    udp_app_in_noc0_ctovr_rdy  = 1'b0;
    udp_app_out_noc0_vrtoc_val = 1'b0;
    in_store_hdr_flit          = 1'b0;
    in_store_meta_flit         = 1'b0;
    out_data_mux_sel           = HDR_FLIT;
    if (!rst) begin
      case (state)
        RX_HDR: begin
          udp_app_in_noc0_ctovr_rdy = 1'b1;
          in_store_hdr_flit         = noc0_ctovr_udp_app_in_val;
        end
        RX_META: begin
          udp_app_in_noc0_ctovr_rdy = 1'b1;
          in_store_meta_flit        = noc0_ctovr_udp_app_in_val;
        end
        TX_HDR: begin
          udp_app_out_noc0_vrtoc_val = 1'b1;
        end
        TX_META: begin
          udp_app_out_noc0_vrtoc_val = 1'b1;
          out_data_mux_sel           = META_FLIT;
        end
        PASS_DATA: begin
          udp_app_in_noc0_ctovr_rdy  = noc0_vrtoc_udp_app_out_rdy;
          udp_app_out_noc0_vrtoc_val = noc0_ctovr_udp_app_in_val;
          out_data_mux_sel           = DATA_FLIT;
        end
        default: ;
      endcase
    end
  end

`ifdef UDP_ECHO_APP_STATS_EN
  // Echoed packet and payload-byte counters, wrapping modulo 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      echo_pkt_count  <= '0;
      echo_byte_count <= '0;
    end else if (pkt_done) begin
      echo_pkt_count  <= echo_pkt_count + 32'd1;
      echo_byte_count <= echo_byte_count + 32'(data_length);
    end
  end
`else
  logic unused_stats_inputs;
  assign unused_stats_inputs = (^data_length) ^ pkt_done;
`endif

endmodule

// File: doc/udp_echo_app_ctrl.md
# udp_echo_app_ctrl

Control FSM for the UDP echo application tile. It sequences `udp_echo_app_datap`:
- accepts an incoming UDP RX message from NoC0 (header flit, one metadata flit, N data flits);
- strobes the datapath to capture header and metadata;
- emits the rewritten TX header and metadata flits;
- streams the data flits straight through to the outbound NoC0 port.

It owns all val/rdy handshakes on both NoC0 sides and the datapath output mux select.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  tile clock; single clock domain
- `rst`  in  1  synchronous, active-high reset
- `noc0_ctovr_udp_app_in_val`  in  1  inbound flit valid
- `udp_app_in_noc0_ctovr_rdy`  out  1  inbound flit ready
- `udp_app_out_noc0_vrtoc_val`  out  1  outbound flit valid
- `noc0_vrtoc_udp_app_out_rdy`  in  1  outbound flit ready
- `in_store_hdr_flit`  out  1  datapath: capture inbound flit as header
- `in_store_meta_flit`  out  1  datapath: capture inbound flit as metadata
- `out_data_mux_sel`  out  `udp_app_out_mux_sel_e`  datapath output select: `HDR_FLIT`, `META_FLIT` or `DATA_FLIT`
- `total_flits`  in  `MSG_LENGTH_WIDTH`  registered header `msg_len` from datapath (flits after header, metadata included)
- `data_length`  in  `UDP_LENGTH_W`  registered UDP payload bytes from datapath
- `echo_pkt_count`  out  32  packets fully echoed (only with `UDP_ECHO_APP_STATS_EN`)
- `echo_byte_count`  out  32  payload bytes echoed (only with `UDP_ECHO_APP_STATS_EN`)

## Operation
States: `RX_HDR`, `RX_META`, `TX_HDR`, `TX_META`, `PASS_DATA`.

- **RX_HDR**
  - in_rdy=1, out_val=0, mux=`HDR_FLIT`.
  - `in_store_hdr_flit` = in_val.
  - On in_val → `RX_META`.
- **RX_META**
  - in_rdy=1, out_val=0, mux=`HDR_FLIT`.
  - `in_store_meta_flit` = in_val.
  - On in_val → `TX_HDR`.
- **TX_HDR**
  - in_rdy=0, out_val=1, mux=`HDR_FLIT`.
  - On out_rdy → `TX_META`.
- **TX_META**
  - in_rdy=0, out_val=1, mux=`META_FLIT`.
  - On out_rdy:
    - data flit count = `total_flits` − 1; load it into a `MSG_LENGTH_WIDTH` down-counter.
    - count 0 → `RX_HDR`; otherwise → `PASS_DATA`.
- **PASS_DATA**
  - mux=`DATA_FLIT`, out_val = in_val, in_rdy = out_rdy. The two sides are combinationally coupled.
  - A beat is in_val & out_rdy. Each beat decrements the counter.
  - The beat that takes the counter from 1 to 0 → `RX_HDR`.

Arithmetic and boundary rules:
- `total_flits` of 0 is malformed. Treat it as 1 (zero data flits); never underflow.
- `total_flits` max (all ones) gives all-ones − 1 data flits. There is no wrap.
- Store strobes are never asserted outside their own state. The datapath registers hold their values through the TX states, so `total_flits`/`data_length` are stable in `TX_META` and `PASS_DATA`.
- `data_length` is not used for sequencing. Flit count is authoritative.
- Back-pressure in TX states holds out_val=1 and the mux constant until out_rdy. A flit is never dropped or duplicated.

## Timing
- Reset: state `RX_HDR`, counter 0, stats counters 0.
  - Outputs during and after reset: in_rdy=1 (first cycle after rst deasserts), out_val=0, store strobes 0, mux=`HDR_FLIT`.
  - While rst=1 all handshake outputs are forced to 0.
  - Reset mid-packet abandons the packet; the next cycle is `RX_HDR`.
- All handshake outputs are combinational from state and inputs. The state is registered.
- Minimum latency, with no back-pressure:
  - header accepted cycle 0, meta cycle 1;
  - TX header cycle 2, TX meta cycle 3;
  - first data flit passes cycle 4 (zero added latency per data flit);
  - next packet header accepted the cycle after the last data beat.
- Throughput in `PASS_DATA`: 1 flit/cycle. Per-packet overhead: 4 cycles.

## Configuration
- `UDP_ECHO_APP_STATS_EN` defined:
  - `echo_pkt_count` increments by 1 when a packet completes (`TX_META` exit to `RX_HDR`, or the last `PASS_DATA` beat).
  - On the same cycle, `echo_byte_count` increments by `data_length`.
  - Both counters wrap modulo 2^32 and reset to 0.
- Undefined: both ports and their counters are absent. Sequencing is identical.

## Test plan
- `total_flits`=3, no back-pressure → strobes at cycles 0/1; out flits HDR, META, DATA, DATA at cycles 2–5; in_rdy=1 at cycle 6.
- `total_flits`=1 (no payload) → HDR and META emitted, return to `RX_HDR` after META; `total_flits`=0 behaves identically.
- out_rdy held low for 5 cycles in `TX_HDR` → out_val stays 1, mux `HDR_FLIT`, in_rdy 0; META follows the cycle after out_rdy rises.
- `PASS_DATA` with in_val and out_rdy toggled independently over 8 data flits → exactly 8 beats forwarded in order; in_rdy tracks out_rdy every cycle.
- rst asserted in `PASS_DATA` after 2 of 6 data flits → next cycle in `RX_HDR`, out_val=0; a fresh 3-flit packet echoes correctly.
- With `UDP_ECHO_APP_STATS_EN`: 3 packets of `data_length` 64, 0, 1500 → `echo_pkt_count`=3, `echo_byte_count`=1564.
